lfsr_share_ctrl: RTL and testbench
==================================

Name: lfsr_share_ctrl

Overview:
Shares one Fibonacci LFSR random source between NUM_REQ requesters.
- Arbitrates pending requests.
- Advances the LFSR LFSR_W steps per grant, so each delivered word is fully refreshed.
- Returns the word with a one-cycle grant pulse.
- Also handles seed loading, with a zero-seed lockup guard.
- Sits between the LFSR datapath and consumers such as LED pattern or dither logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LFSR_W, 8, LFSR width in bits (4..16).
- TAPS, 8'hB8, feedback tap mask. Bit i set means lfsr[i] is XORed into the feedback.
- SEED, 8'h01, reset seed. Also substituted whenever a zero seed is loaded. Must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until its gnt bit pulses
- seed_load  in  1  single-cycle pulse to load seed_val
- seed_val  in  LFSR_W  seed value to load
- gnt  out  NUM_REQ  one-hot grant, high for exactly one cycle
- rnd_valid  out  1  high in the same cycle as gnt
- rnd_data  out  LFSR_W  random word; valid with rnd_valid, then held until the next delivery
- busy  out  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, lfsr=SEED, rr pointer=0.
  - gnt=0, rnd_valid=0, rnd_data=0, busy=0.
  - Asserting rst mid-operation aborts the transaction with no gnt issued.
- LFSR step: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}. All arithmetic is LFSR_W wide.
- FSM states: IDLE, STEP, DELIVER.
- IDLE:
  - If seed_load=1: lfsr <= (seed_val==0) ? SEED : seed_val. Stay in IDLE; any pending req is served next cycle. seed_load has priority over req.
  - Else if |req: latch winner index, step_cnt <= LFSR_W-1, go to STEP.
- STEP: advance lfsr once per cycle. When step_cnt==0, go to DELIVER; otherwise decrement step_cnt.
- DELIVER: gnt[winner]=1, rnd_valid=1, rnd_data=lfsr (registered). Go to IDLE next cycle.
- Latency: req sampled in IDLE at cycle t. STEP occupies t+1..t+LFSR_W. gnt and rnd_valid are high in cycle t+LFSR_W+1.
- Throughput: one grant per LFSR_W+2 cycles when requests are continuous.
- seed_load while busy=1 is ignored and not queued.
- req changes during STEP or DELIVER do not alter the latched winner. A requester that drops req mid-transaction still receives its pulse.
- All outputs are registered; no combinational paths from input to output.
- Arbitration: fixed priority, lowest index wins (default build).

Optional Feature:
Macro LFSR_SHARE_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at the rr pointer.
  - On entering STEP, the pointer becomes winner+1, modulo NUM_REQ.
  - No requester waits more than NUM_REQ-1 grants.
- Undefined: fixed priority, lowest index wins; the rr pointer logic is not synthesised.

Decomposition:
- Package lfsr_share_pkg:
  - state enum type (IDLE, STEP, DELIVER).
  - Default TAPS constant per width (4:4'hC, 8:8'hB8, 16:16'hB400).
  - Default SEED constant.
- Sub-module lfsr_core (LFSR_W, TAPS, SEED):
  - Registered LFSR with ld (plus load value) and adv enables.
  - ld has priority.
  - Zero-load replacement with SEED is done inside this sub-module.
- The FSM and arbiter stay in lfsr_share_ctrl.

Test Plan:
- Reset, then req=4'b0001 held:
  - gnt=4'b0001 and rnd_valid=1 exactly 9 cycles after the IDLE sample cycle.
  - rnd_data=8'h1C (SEED 8'h01 advanced 8 steps).
  - busy is high for 9 cycles.
- seed_load=1 with seed_val=8'h00 in IDLE, then one request → rnd_data=8'h1C (zero replaced by SEED).
- seed_load=1 with seed_val=8'h08 and req=4'b0010 in the same IDLE cycle:
  - The seed is loaded first.
  - The grant goes to bit 1 one cycle later than normal.
  - rnd_data is 8'h08 advanced 8 steps.
- req=4'b1111 held for 8 grants:
  - Default build: gnt always 4'b0001.
  - With LFSR_SHARE_RR_EN: gnt sequence 0001, 0010, 0100, 1000, repeating.
- Assert rst during STEP (cycle t+4):
  - No gnt is issued.
  - Outputs return to their reset values.
  - The next request returns 8'h1C.
- seed_load=1 (seed_val=8'h55) while busy=1 → ignored; the next delivered words match the unseeded sequence, and 255 consecutive single steps of the LFSR visit 255 distinct nonzero values.

Source files
------------

// File: rtl/lfsr_share_pkg.sv
// Shared types and defaults for the shared-LFSR random source.
package lfsr_share_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StDeliver
    } state_e;

    localparam logic [15:0] DefaultSeed = 16'h0001;

    // Known maximal-length tap masks; other widths fall back to the top two bits.
    function automatic logic [15:0] default_taps(input int unsigned width);
        logic [15:0] taps;
        unique case (width)
            4:       taps = 16'h000C;
            8:       taps = 16'h00B8;
            16:      taps = 16'hB400;
            default: taps = (16'h1 << (width - 1)) | (16'h1 << (width - 2));
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_share_ctrl_core.sv
// Registered Fibonacci LFSR with load (priority) and advance enables.
// A zero load value is replaced by SEED so the register can never lock up.
module lfsr_share_ctrl_core
    import lfsr_share_pkg::*;
#(
    parameter int unsigned          LFSR_W = 8,
    parameter logic [LFSR_W-1:0]    TAPS   = LFSR_W'(default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0]    SEED   = LFSR_W'(DefaultSeed)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_i,
    input  logic [LFSR_W-1:0] ld_val_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] nxt_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Next-state: load beats advance; nxt_o is always the one-step-ahead value.
    always_comb begin
        nxt_o  = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        lfsr_d = lfsr_q;
        if (ld_i) begin
            lfsr_d = (ld_val_i == '0) ? SEED : ld_val_i;
        end else if (adv_i) begin
            lfsr_d = nxt_o;
        end
    end

    // LFSR register, synchronous reset to SEED.
    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Arbitrates NUM_REQ requesters onto one LFSR, stepping it LFSR_W times per grant.
// Build option: LFSR_SHARE_RR_EN selects round-robin arbitration (default fixed priority).
module lfsr_share_ctrl
    import lfsr_share_pkg::*;
#(
    parameter int unsigned          NUM_REQ = 4,
    parameter int unsigned          LFSR_W  = 8,
    parameter logic [LFSR_W-1:0]    TAPS    = LFSR_W'(default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0]    SEED    = LFSR_W'(DefaultSeed)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_val,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [LFSR_W-1:0]  rnd_data,
    output logic               busy
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(LFSR_W);

    state_e             state_q, state_d;
    logic [IdxW-1:0]    winner_q, winner_d;
    logic [CntW-1:0]    step_cnt_q, step_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic [LFSR_W-1:0]  rnd_data_q, rnd_data_d;
    logic               busy_q, busy_d;
    logic [IdxW-1:0]    pick;
    logic               ld, adv;
    logic [LFSR_W-1:0]  lfsr_nxt;

`ifdef LFSR_SHARE_RR_EN
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        logic found;
        int   cand;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = IdxW'(cand);
            end
        end
    end
`else
    // Fixed-priority pick: lowest index wins.
    always_comb begin
        pick = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) pick = IdxW'(i);
        end
    end
`endif

    lfsr_share_ctrl_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_core (
        .clk_i    (clk),
        .rst_i    (rst),
        .ld_i     (ld),
        .ld_val_i (seed_val),
        .adv_i    (adv),
        .nxt_o    (lfsr_nxt)
    );

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        step_cnt_d  = step_cnt_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        ld          = 1'b0;
        adv         = 1'b0;
`ifdef LFSR_SHARE_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (seed_load) begin
                    ld = 1'b1;
                end else if (|req) begin
                    winner_d   = pick;
                    step_cnt_d = CntW'(LFSR_W - 1);
                    state_d    = StStep;
`ifdef LFSR_SHARE_RR_EN
                    rr_ptr_d   = (pick == IdxW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
`endif
                end
            end
            StStep: begin
                adv = 1'b1;
                if (step_cnt_q == '0) begin
                    // Capture the post-step word so it is valid alongside gnt.
                    state_d     = StDeliver;
                    gnt_d       = NUM_REQ'(1) << winner_q;
                    rnd_valid_d = 1'b1;
                    rnd_data_d  = lfsr_nxt;
                end else begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
            end
            StDeliver: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            winner_q    <= '0;
            step_cnt_q  <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef LFSR_SHARE_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            step_cnt_q  <= step_cnt_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            busy_q      <= busy_d;
`ifdef LFSR_SHARE_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench for lfsr_share_ctrl (NUM_REQ=4, LFSR_W=8, TAPS=8'hB8, SEED=8'h01).
module tb_lfsr_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_val = '0;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [7:0] rnd_data;
    logic       busy;

    lfsr_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] m;          // reference LFSR state
    logic [7:0] last_data;
    bit         seen[256];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] step1(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic logic [7:0] step8(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < 8; i++) r = step1(r);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Monitor: every delivered word is compared against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rnd_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant actual gnt=%b required no grant", gnt);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_gnt", 32'(gnt), 32'(e.gnt));
                        check("sb_data", 32'(rnd_data), 32'(e.data));
                    end
                end else if (gnt != '0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_without_valid actual gnt=%b required 0000", gnt);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req       = '0;
        seed_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m   = 8'h01;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_valid"}, 32'(rnd_valid), 0);
        check({tag, "_data"}, 32'(rnd_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One request transaction. seed_at: <0 none, 0 with the request, >0 that many cycles later.
    task automatic req_txn(input logic [3:0] mask, input logic [3:0] egnt, input logic [7:0] edata,
                           input int seed_at, input logic [7:0] sval, input int elat,
                           input string name);
        int c0, lat, bc;
        bit got;
        bc  = 0;
        got = 0;
        lat = 0;
        @(negedge clk);
        c0  = cyc;
        req = mask;
        if (seed_at == 0) begin
            seed_load = 1'b1;
            seed_val  = sval;
        end
        exp_q.push_back('{gnt: egnt, data: edata});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seed_load = (seed_at > 0) && (i + 1 == seed_at);
            seed_val  = sval;
            if (busy) bc++;
            if (rnd_valid) begin
                got       = 1;
                lat       = cyc - c0;
                last_data = rnd_data;
                break;
            end
        end
        req       = '0;
        seed_load = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual no grant required grant within 40 cycles", name);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(elat));
            check({name, "_busy_cycles"}, 32'(bc), 9);
        end
    endtask

    initial begin
        int n_got, distinct_ok;
        m = 8'h01;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic grant: SEED advanced 8 steps is 8'h1C.
        req_txn(4'b0001, 4'b0001, 8'h1C, -1, 8'h00, 9, "basic");

        // Zero seed is replaced by SEED.
        do_reset();
        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        req_txn(4'b0001, 4'b0001, 8'h1C, -1, 8'h00, 9, "zero_seed");

        // Seed and request together: seed first, grant one cycle late; 8'h08 -> 8'hE2.
        do_reset();
        req_txn(4'b0010, 4'b0010, 8'hE2, 0, 8'h08, 10, "seed_and_req");

        // All requesters held for 8 grants.
        do_reset();
        @(negedge clk);
        req = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            m = step8(m);
`ifdef LFSR_SHARE_RR_EN
            exp_q.push_back('{gnt: 4'b0001 << (g % 4), data: m});
`else
            exp_q.push_back('{gnt: 4'b0001, data: m});
`endif
        end
        n_got = 0;
        for (int i = 0; i < 200 && n_got < 8; i++) begin
            @(negedge clk);
            if (rnd_valid) n_got++;
        end
        req = '0;
        check("held_grant_count", 32'(n_got), 8);

        // Reset in the middle of STEP aborts the transaction.
        @(negedge clk);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        m   = 8'h01;
        check_reset_outputs("abort");
        repeat (15) @(negedge clk);
        check("abort_no_pending", 32'(exp_q.size()), 0);
        req_txn(4'b0001, 4'b0001, 8'h1C, -1, 8'h00, 9, "after_abort");
        m = 8'h1C;

        // seed_load while busy is ignored.
        m = step8(m);
        req_txn(4'b0001, 4'b0001, m, 3, 8'h55, 9, "seed_busy");
        m = step8(m);
        req_txn(4'b0001, 4'b0001, m, -1, 8'h00, 9, "seed_busy_next");

        // 255 deliveries (8 steps each, coprime with 255) cover every nonzero state once.
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        distinct_ok = 1;
        for (int k = 0; k < 255; k++) begin
            m = step8(m);
            req_txn(4'b0001, 4'b0001, m, -1, 8'h00, 9, "seq");
            if (last_data == 8'h00 || seen[last_data]) distinct_ok = 0;
            seen[last_data] = 1'b1;
        end
        check("seq_distinct_nonzero", 32'(distinct_ok), 1);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
